mlt3_tx_scheduler: RTL

- Transmit-side PMA scheduler sitting between the 4B/5B PCS and the MLT-3 line encoder.
- Accepts 5-bit code groups over a valid/ready handshake and serialises them LSB-first onto a single NRZ bit.
- Fills idle time with IDLE code groups, counts underruns, and brings the line up and down cleanly on tx_enable.

---
 rtl/mlt3_tx_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mlt3_tx_scheduler.sv
// rtl/mlt3_tx_scheduler.sv - 4B/5B code-group serialiser with IDLE fill and underrun count for MLT-3 TX
// Optional PRBS7 line test mode under MLT3_TX_SCHED_PRBS_EN.
module mlt3_tx_scheduler #(
   parameter int         CLKS_PER_BIT = 1,
   parameter logic [4:0] IDLE_CG      = 5'b11111,
   parameter int         CNT_W        = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             tx_enable,
`ifdef MLT3_TX_SCHED_PRBS_EN
   input  logic             test_mode,
`endif
   input  logic [4:0]       cg_data,
   input  logic             cg_valid,
   output logic             cg_ready,
   output logic             nrz,
   output logic             bit_strobe,
   output logic             tx_active,
   output logic             underrun,
   output logic [CNT_W-1:0] underrun_count
);

   typedef enum logic [1:0] {OFF, IDLE, DATA} state_t;

   localparam logic [3:0] TMAX = 4'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t     state;
   logic [4:0] shift_reg;
   logic [2:0] bit_idx;
   logic [3:0] timer;
   logic       boundary;
   logic       tm;
   logic       prbs_bit;

   assign bit_strobe = (state != OFF) && (timer == TMAX);
   assign boundary   = bit_strobe && (bit_idx == 3'd4);
   assign tx_active  = (state != OFF);
   assign cg_ready   = boundary && tx_enable && !tm;

`ifdef MLT3_TX_SCHED_PRBS_EN
   logic [6:0] prbs;
   logic       prbs_step;

   assign tm        = test_mode;
   assign prbs_bit  = prbs[6] ^ prbs[5];
   // Advance exactly when a PRBS bit is loaded into nrz.
   assign prbs_step = tm && (((state == OFF) && tx_enable) ||
                             (bit_strobe && !(boundary && !tx_enable)));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         prbs <= 7'h7F;
      else if (prbs_step)
         prbs <= {prbs[5:0], prbs_bit};
   end
`else
   assign tm       = 1'b0;
   assign prbs_bit = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= OFF;
         nrz            <= 1'b0;
         underrun       <= 1'b0;
         underrun_count <= '0;
         shift_reg      <= '0;
         bit_idx        <= '0;
         timer          <= '0;
      end else begin
         underrun <= 1'b0;
         case (state)
            OFF: begin
               timer   <= '0;
               bit_idx <= '0;
               if (tx_enable) begin
                  state     <= IDLE;
                  nrz       <= tm ? prbs_bit : IDLE_CG[0];
                  shift_reg <= IDLE_CG >> 1;
               end else begin
                  nrz       <= 1'b0;
                  shift_reg <= '0;
               end
            end
            default: begin
               timer <= bit_strobe ? 4'd0 : timer + 4'd1;
               if (boundary) begin
                  bit_idx <= '0;
                  if (!tx_enable) begin
                     state     <= OFF;
                     nrz       <= 1'b0;
                     shift_reg <= '0;
                  end else if (tm) begin
                     state     <= IDLE;
                     nrz       <= prbs_bit;
                     shift_reg <= IDLE_CG >> 1;
                  end else if (cg_valid) begin
                     state     <= DATA;
                     nrz       <= cg_data[0];
                     shift_reg <= cg_data >> 1;
                  end else begin
                     // Running dry after a PCS group is an underrun; idle-to-idle is not.
                     state     <= IDLE;
                     nrz       <= IDLE_CG[0];
                     shift_reg <= IDLE_CG >> 1;
                     if (state == DATA) begin
                        underrun <= 1'b1;
                        if (underrun_count != {CNT_W{1'b1}})
                           underrun_count <= underrun_count + CNT_ONE;
                     end
                  end
               end else if (bit_strobe) begin
                  bit_idx   <= bit_idx + 3'd1;
                  nrz       <= tm ? prbs_bit : shift_reg[0];
                  shift_reg <= shift_reg >> 1;
               end
            end
         endcase
      end
   end

endmodule
